// File: rtl/hams_merge_sort_colq_fifo_if.sv
// Handshake bundle between the column-queue controller (master) and the FIFO (slave).
// Carries push/pop requests, lane-packed data and the occupancy/status flags.
interface hams_merge_sort_colq_fifo_if #(
  parameter int NUM_MEM    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int PTR_W = $clog2(DEPTH) + 1;

  logic                          flush;
  logic                          fifo_push;
  logic [NUM_MEM*DATA_WIDTH-1:0] wr_data;
  logic                          fifo_pop;
  logic [NUM_MEM*DATA_WIDTH-1:0] rd_data;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic [PTR_W-1:0]              count;
  logic                          overflow;

  modport master (
    output flush, fifo_push, wr_data, fifo_pop,
    input  rd_data, fifo_full, fifo_empty, count, overflow
  );

  modport slave (
    input  flush, fifo_push, wr_data, fifo_pop,
    output rd_data, fifo_full, fifo_empty, count, overflow
  );
endinterface

// File: rtl/hams_merge_sort_colq_fifo.sv
// First-word-fall-through column queue with wrap-bit pointers and a sticky overflow flag.
// Optional macro HAMS_COLQ_LANE_SORT_EN sorts each entry's lanes ascending before storage.
module hams_merge_sort_colq_fifo #(
  parameter int NUM_MEM    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  hams_merge_sort_colq_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = NUM_MEM * DATA_WIDTH;

  logic [EW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] store_data;
  logic          overflow_q;
  logic          full;
  logic          empty;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok  = bus.fifo_pop && !empty;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign push_ok = bus.fifo_push && (!full || pop_ok);

`ifdef HAMS_COLQ_LANE_SORT_EN
  // Odd-even transposition network; strict compare keeps equal lanes in input order.
  logic [DATA_WIDTH-1:0] lanes [NUM_MEM];
  logic [DATA_WIDTH-1:0] tmp;

  always_comb begin
    tmp        = '0;
    store_data = '0;
    for (int i = 0; i < NUM_MEM; i++) begin
      lanes[i] = bus.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int p = 0; p < NUM_MEM; p++) begin
      for (int j = p % 2; j + 1 < NUM_MEM; j += 2) begin
        if (lanes[j] > lanes[j+1]) begin
          tmp        = lanes[j];
          lanes[j]   = lanes[j+1];
          lanes[j+1] = tmp;
        end
      end
    end
    for (int i = 0; i < NUM_MEM; i++) begin
      store_data[i*DATA_WIDTH +: DATA_WIDTH] = lanes[i];
    end
  end
`else
  assign store_data = bus.wr_data;
`endif

  // Flush wins over any same-cycle push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (bus.fifo_push && !push_ok) overflow_q <= 1'b1;
    end
  end

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk) begin
    if (push_ok && !bus.flush) mem[wr_ptr[AW-1:0]] <= store_data;
  end

  assign bus.rd_data    = mem[rd_ptr[AW-1:0]];
  assign bus.fifo_full  = full;
  assign bus.fifo_empty = empty;
  assign bus.count      = wr_ptr - rd_ptr;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_hams_merge_sort_colq_fifo.sv
// Directed self-checking bench for hams_merge_sort_colq_fifo (default 4x32-bit lanes, depth 16).
// Expected lane order follows HAMS_COLQ_LANE_SORT_EN when the bench is built with it.
module tb_hams_merge_sort_colq_fifo;
  localparam int NM = 4;
  localparam int DW = 32;
  localparam int DP = 16;
  localparam int W  = NM * DW;

  logic clk;
  logic rst_n;
  int   checks;
  int   passed;

  hams_merge_sort_colq_fifo_if #(.NUM_MEM(NM), .DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  hams_merge_sort_colq_fifo #(.NUM_MEM(NM), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         push;
    logic         pop;
    logic         fl;
    logic [W-1:0] d;
    logic [4:0]   cnt;
    logic         emp;
    logic         ful;
    logic         ovf;
    logic         chk_rd;
    logic [W-1:0] rd;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [W-1:0] lanes4(input int a, input int b, input int c, input int d);
    logic [W-1:0] r;
    r = {d[DW-1:0], c[DW-1:0], b[DW-1:0], a[DW-1:0]};
    return r;
  endfunction

  // Value the queue is expected to hand back for a given pushed word.
  function automatic logic [W-1:0] exp_store(input logic [W-1:0] d);
    logic [W-1:0]    r;
    logic [DW-1:0]   v [NM];
    logic [DW-1:0]   key;
    int              k;
    for (int i = 0; i < NM; i++) v[i] = d[i*DW +: DW];
`ifdef HAMS_COLQ_LANE_SORT_EN
    for (int i = 1; i < NM; i++) begin
      key = v[i];
      k   = i - 1;
      while (k >= 0 && v[k] > key) begin
        v[k+1] = v[k];
        k      = k - 1;
      end
      v[k+1] = key;
    end
`else
    key = '0;
    k   = 0;
`endif
    for (int i = 0; i < NM; i++) r[i*DW +: DW] = v[i];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic checkStatus(input string tag, input int cnt, input logic emp,
                             input logic ful, input logic ovf);
    checkOutput({tag, "_count"},    W'(bus.count),      W'(cnt));
    checkOutput({tag, "_empty"},    W'(bus.fifo_empty), W'(emp));
    checkOutput({tag, "_full"},     W'(bus.fifo_full),  W'(ful));
    checkOutput({tag, "_overflow"}, W'(bus.overflow),   W'(ovf));
  endtask

  task automatic applyStimulus(input logic push, input logic pop, input logic fl, input logic [W-1:0] d);
    bus.fifo_push = push;
    bus.fifo_pop  = pop;
    bus.flush     = fl;
    bus.wr_data   = d;
    @(posedge clk);
    #1;
    bus.fifo_push = 1'b0;
    bus.fifo_pop  = 1'b0;
    bus.flush     = 1'b0;
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, 1'b0, lanes4(i, i+1, i+2, i+3));
  endtask

  initial begin
    logic [W-1:0] q [$];
    logic [W-1:0] d;
    logic         do_push;
    logic         do_pop;

    checks = 0;
    passed = 0;
    rst_n  = 1'b0;
    bus.flush = 1'b0; bus.fifo_push = 1'b0; bus.fifo_pop = 1'b0; bus.wr_data = '0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, lanes4(1,2,3,4),     5'd1, 1'b0, 1'b0, 1'b0, 1'b1, lanes4(1,2,3,4)};
    vecs[1] = '{1'b1, 1'b1, 1'b0, lanes4(5,6,7,8),     5'd1, 1'b0, 1'b0, 1'b0, 1'b1, lanes4(5,6,7,8)};
    vecs[2] = '{1'b0, 1'b1, 1'b0, '0,                  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, '0,                  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, lanes4(10,20,30,40), 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, lanes4(10,20,30,40)};
    vecs[5] = '{1'b1, 1'b1, 1'b1, lanes4(50,51,52,53), 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, '0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, lanes4(60,61,62,63), 5'd1, 1'b0, 1'b0, 1'b0, 1'b1, lanes4(60,61,62,63)};

    #1;
    checkStatus("reset", 0, 1'b1, 1'b0, 1'b0);
    #20;
    rst_n = 1'b1;

    // Fill to full, then drain in order.
    fill16();
    checkStatus("filled", 16, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      checkOutput($sformatf("drain_%0d", i), bus.rd_data, lanes4(i, i+1, i+2, i+3));
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
    end
    checkStatus("drained", 0, 1'b1, 1'b0, 1'b0);

    // Overflow on full, sticky, cleared by flush.
    fill16();
    applyStimulus(1'b1, 1'b0, 1'b0, lanes4(99,99,99,99));
    checkStatus("ovf_push", 16, 1'b0, 1'b1, 1'b1);
    checkOutput("ovf_head", bus.rd_data, lanes4(0,1,2,3));
    applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("ovf_sticky", W'(bus.overflow), W'(1));
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    checkStatus("ovf_flush", 0, 1'b1, 1'b0, 1'b0);

    // Push and pop together while full.
    fill16();
    checkOutput("fullpp_head", bus.rd_data, lanes4(0,1,2,3));
    applyStimulus(1'b1, 1'b1, 1'b0, lanes4(77,77,77,77));
    checkStatus("fullpp", 16, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      checkOutput($sformatf("fullpp_pop_%0d", i), bus.rd_data, lanes4(i, i+1, i+2, i+3));
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
    end
    checkOutput("fullpp_pop_16", bus.rd_data, lanes4(77,77,77,77));
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkStatus("fullpp_end", 0, 1'b1, 1'b0, 1'b0);

    // Pop held on empty, push in the last cycle.
    for (int c = 0; c < 5; c++) applyStimulus(c == 4, 1'b1, 1'b0, lanes4(5,5,5,5));
    checkStatus("emptypop", 1, 1'b0, 1'b0, 1'b0);
    checkOutput("emptypop_rd", bus.rd_data, lanes4(5,5,5,5));

    // Table-driven vectors from a flushed queue.
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].push, vecs[v].pop, vecs[v].fl, vecs[v].d);
      checkStatus($sformatf("vec%0d", v), int'(vecs[v].cnt), vecs[v].emp, vecs[v].ful, vecs[v].ovf);
      if (vecs[v].chk_rd) checkOutput($sformatf("vec%0d_rd", v), bus.rd_data, vecs[v].rd);
    end

    // Random traffic at low occupancy across pointer wrap.
    applyStimulus(1'b0, 1'b0, 1'b1, '0);
    for (int c = 0; c < 40; c++) begin
      d       = {$urandom, $urandom, $urandom, $urandom};
      do_push = 1'b1;
      do_pop  = (q.size() == 3) || (q.size() > 0 && $urandom_range(0, 1) == 1);
      if (do_pop) checkOutput($sformatf("rand_rd_%0d", c), bus.rd_data, q[0]);
      applyStimulus(do_push, do_pop, 1'b0, d);
      if (do_pop) void'(q.pop_front());
      q.push_back(exp_store(d));
      checkOutput($sformatf("rand_cnt_%0d", c), W'(bus.count), W'(q.size()));
    end
    while (q.size() > 0) begin
      checkOutput("rand_drain", bus.rd_data, q[0]);
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      void'(q.pop_front());
    end
    checkStatus("rand_end", 0, 1'b1, 1'b0, 1'b0);

    // Lane ordering within one entry.
    applyStimulus(1'b1, 1'b0, 1'b0, lanes4(9,2,7,2));
`ifdef HAMS_COLQ_LANE_SORT_EN
    checkOutput("lane_order", bus.rd_data, lanes4(2,2,7,9));
`else
    checkOutput("lane_order", bus.rd_data, lanes4(9,2,7,2));
`endif

    // Asynchronous reset mid-operation.
    applyStimulus(1'b1, 1'b0, 1'b0, lanes4(30,31,32,33));
    applyStimulus(1'b1, 1'b0, 1'b0, lanes4(34,35,36,37));
    rst_n = 1'b0;
    #1;
    checkStatus("midreset", 0, 1'b1, 1'b0, 1'b0);
    #3;
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, lanes4(11,12,13,14));
    checkStatus("postreset", 1, 1'b0, 1'b0, 1'b0);
    checkOutput("postreset_rd", bus.rd_data, lanes4(11,12,13,14));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
